// File: rtl/vga_scanout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_scanout_pkg
// Description : Shared constants and helpers for the VGA scanout block.
//               Holds the default 640x480@60 timing/window set plus constant
//               functions for total/max counter values, sync boundaries,
//               words-per-line, pixels-per-word and log2.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_scanout_pkg;

    // Default 640x480@60 timing with a 512x256 1-bpp window centred on screen
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_BOTTOM  = 11;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_TOP     = 31;
    localparam int DEF_WIN_X     = 64;
    localparam int DEF_WIN_Y     = 112;
    localparam int DEF_WIN_W     = 512;
    localparam int DEF_WIN_H     = 256;

    // Last counter value of a line/frame (H_MAX / V_MAX)
    function automatic int count_max(input int disp, input int porch_a,
                                     input int sync, input int porch_b);
        return disp + porch_a + sync + porch_b - 1;
    endfunction

    // First counter value of the sync pulse
    function automatic int sync_start(input int disp, input int porch_a);
        return disp + porch_a;
    endfunction

    // First counter value after the sync pulse
    function automatic int sync_end(input int disp, input int porch_a, input int sync);
        return disp + porch_a + sync;
    endfunction

    // VRAM words per window line
    function automatic int words_per_line(input int win_w, input int scale,
                                          input int bpp, input int data_w);
        return win_w / scale * bpp / data_w;
    endfunction

    // Pixels packed into one VRAM word
    function automatic int pix_per_word(input int data_w, input int bpp);
        return data_w / bpp;
    endfunction

    // ceil(log2(value)); exact log2 for powers of two
    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Bit width needed to hold 0..value-1, never less than one
    function automatic int width_of(input int value);
        int r;
        r = log2_ceil(value);
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_scanout_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_scanout_if
// Description : Bundle between the scanout engine, its VRAM read port and the
//               VGA pins / palette DAC.
//   base_addr    : frame base word address (into scanout)
//   data_vram    : VRAM read data, one clock after address_vram (into scanout)
//   address_vram : VRAM word address (from scanout)
//   hsync/vsync  : sync outputs (from scanout)
//   de           : visible-area strobe (from scanout)
//   pixel        : pixel index (from scanout)
//   frame_start  : pulse with output of position (0,0) (from scanout)
//   Modports     : master = scanout engine, slave = VRAM/board side
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_scanout_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int BPP    = 1
);
    logic [ADDR_W-1:0] base_addr;
    logic [DATA_W-1:0] data_vram;
    logic [ADDR_W-1:0] address_vram;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic [BPP-1:0]    pixel;
    logic              frame_start;

    modport master (
        input  base_addr, data_vram,
        output address_vram, hsync, vsync, de, pixel, frame_start
    );

    modport slave (
        output base_addr, data_vram,
        input  address_vram, hsync, vsync, de, pixel, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Horizontal/vertical counters and the raw (unregistered,
//               polarity-free) flags derived from them.
//   clk, rst   : pixel clock, synchronous active-high reset
//   o_xoff     : h - WIN_X (modulo counter width)
//   o_yoff     : v - WIN_Y (modulo counter width)
//   o_hact     : h inside the hsync pulse
//   o_vact     : v inside the vsync pulse
//   o_de       : h,v inside the visible area
//   o_in_win   : h,v inside the pixel window
//   o_wrap     : counters at (H_MAX,V_MAX); next edge returns to (0,0)
//   o_origin   : counters at (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_scanout_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_BOTTOM  = DEF_V_BOTTOM,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_TOP     = DEF_V_TOP,
    parameter int WIN_X     = DEF_WIN_X,
    parameter int WIN_Y     = DEF_WIN_Y,
    parameter int WIN_W     = DEF_WIN_W,
    parameter int WIN_H     = DEF_WIN_H,
    parameter int H_W       = 10,
    parameter int V_W       = 10
) (
    input  logic           clk,
    input  logic           rst,
    output logic [H_W-1:0] o_xoff,
    output logic [V_W-1:0] o_yoff,
    output logic           o_hact,
    output logic           o_vact,
    output logic           o_de,
    output logic           o_in_win,
    output logic           o_wrap,
    output logic           o_origin
);

    localparam logic [H_W-1:0] C_H_MAX    = H_W'(count_max(H_DISPLAY, H_FRONT, H_SYNC, H_BACK));
    localparam logic [V_W-1:0] C_V_MAX    = V_W'(count_max(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP));
    localparam logic [H_W-1:0] C_HS_START = H_W'(sync_start(H_DISPLAY, H_FRONT));
    localparam logic [H_W-1:0] C_HS_END   = H_W'(sync_end(H_DISPLAY, H_FRONT, H_SYNC));
    localparam logic [V_W-1:0] C_VS_START = V_W'(sync_start(V_DISPLAY, V_BOTTOM));
    localparam logic [V_W-1:0] C_VS_END   = V_W'(sync_end(V_DISPLAY, V_BOTTOM, V_SYNC));
    localparam logic [H_W-1:0] C_H_DISP   = H_W'(H_DISPLAY);
    localparam logic [V_W-1:0] C_V_DISP   = V_W'(V_DISPLAY);
    localparam logic [H_W-1:0] C_WIN_X    = H_W'(WIN_X);
    localparam logic [V_W-1:0] C_WIN_Y    = V_W'(WIN_Y);
    localparam logic [H_W-1:0] C_WIN_W    = H_W'(WIN_W);
    localparam logic [V_W-1:0] C_WIN_H    = V_W'(WIN_H);

    logic [H_W-1:0] r_h;
    logic [V_W-1:0] r_v;
    logic           w_h_last;
    logic           w_v_last;

    assign w_h_last = (r_h == C_H_MAX);
    assign w_v_last = (r_v == C_V_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Offsets wrap below the window start, so a single unsigned compare
    // against the window size covers both window edges (and works for WIN_X=0).
    assign o_xoff   = r_h - C_WIN_X;
    assign o_yoff   = r_v - C_WIN_Y;
    assign o_in_win = (o_xoff < C_WIN_W) && (o_yoff < C_WIN_H);

    assign o_hact   = (r_h >= C_HS_START) && (r_h < C_HS_END);
    assign o_vact   = (r_v >= C_VS_START) && (r_v < C_VS_END);
    assign o_de     = (r_h < C_H_DISP) && (r_v < C_V_DISP);
    assign o_wrap   = w_h_last && w_v_last;
    assign o_origin = (r_h == '0) && (r_v == '0);

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module      : vga_scanout
// Description : VGA timing plus windowed packed-pixel fetch from a
//               synchronous-read VRAM. Fixed two-clock latency from counter
//               position to every output, so sync and pixel never skew.
//   clk, rst : pixel clock, synchronous active-high reset
//   bus      : vga_scanout_if.master (base_addr, data_vram in;
//              address_vram, hsync, vsync, de, pixel, frame_start out)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_BOTTOM  = DEF_V_BOTTOM,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_TOP     = DEF_V_TOP,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int WIN_X     = DEF_WIN_X,
    parameter int WIN_Y     = DEF_WIN_Y,
    parameter int WIN_W     = DEF_WIN_W,
    parameter int WIN_H     = DEF_WIN_H,
    parameter int BPP       = 1,
    parameter int SCALE     = 1,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 13
) (
    input  logic          clk,
    input  logic          rst,
    vga_scanout_if.master bus
);

    localparam int H_W      = width_of(count_max(H_DISPLAY, H_FRONT, H_SYNC, H_BACK) + 1);
    localparam int V_W      = width_of(count_max(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP) + 1);
    localparam int WPL      = words_per_line(WIN_W, SCALE, BPP, DATA_W);
    localparam int PPW      = pix_per_word(DATA_W, BPP);
    localparam int PPW_SH   = log2_ceil(PPW);
    localparam int SCALE_SH = log2_ceil(SCALE);
    localparam int SEL_W    = width_of(PPW);

    localparam logic C_HS_ON = (HSYNC_POL != 0);
    localparam logic C_VS_ON = (VSYNC_POL != 0);

    // ---------------------------------------------------------------- checks
    if (WIN_X + WIN_W > H_DISPLAY) begin : g_chk_win_x
        $error("vga_scanout: window exceeds H_DISPLAY");
    end
    if (WIN_Y + WIN_H > V_DISPLAY) begin : g_chk_win_y
        $error("vga_scanout: window exceeds V_DISPLAY");
    end
    if (((WIN_W / SCALE * BPP) % DATA_W) != 0) begin : g_chk_wpl
        $error("vga_scanout: window line is not a whole number of VRAM words");
    end
    if (BPP != 1 && BPP != 2 && BPP != 4) begin : g_chk_bpp
        $error("vga_scanout: BPP must be 1, 2 or 4");
    end
    if (SCALE != 1 && SCALE != 2) begin : g_chk_scale
        $error("vga_scanout: SCALE must be 1 or 2");
    end

    // ---------------------------------------------------------------- timing
    logic [H_W-1:0] w_xoff;
    logic [V_W-1:0] w_yoff;
    logic           w_hact;
    logic           w_vact;
    logic           w_de;
    logic           w_in_win;
    logic           w_wrap;
    logic           w_origin;

    vga_timing_gen #(
        .H_DISPLAY (H_DISPLAY),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_DISPLAY (V_DISPLAY),
        .V_BOTTOM  (V_BOTTOM),
        .V_SYNC    (V_SYNC),
        .V_TOP     (V_TOP),
        .WIN_X     (WIN_X),
        .WIN_Y     (WIN_Y),
        .WIN_W     (WIN_W),
        .WIN_H     (WIN_H),
        .H_W       (H_W),
        .V_W       (V_W)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .o_xoff   (w_xoff),
        .o_yoff   (w_yoff),
        .o_hact   (w_hact),
        .o_vact   (w_vact),
        .o_de     (w_de),
        .o_in_win (w_in_win),
        .o_wrap   (w_wrap),
        .o_origin (w_origin)
    );

    // ------------------------------------------------------ address generation
    logic [ADDR_W-1:0] r_base;
    logic [H_W-1:0]    w_sx;
    logic [V_W-1:0]    w_sy;
    logic [SEL_W-1:0]  w_sel;
    logic [ADDR_W-1:0] w_addr_win;

    // The base is taken on the same edge the counters return to (0,0), so a
    // whole frame is always fetched from one buffer.
    always_ff @(posedge clk) begin
        if (rst || w_wrap) begin
            r_base <= bus.base_addr;
        end
    end

    assign w_sx  = w_xoff >> SCALE_SH;
    assign w_sy  = w_yoff >> SCALE_SH;
    assign w_sel = SEL_W'(32'(w_sx) & 32'(PPW - 1));

    // Sum is truncated to ADDR_W so the window wraps around the VRAM space.
    assign w_addr_win = r_base
                      + ADDR_W'(32'(w_sy) * 32'(WPL))
                      + ADDR_W'(32'(w_sx) >> PPW_SH);

    assign bus.address_vram = w_in_win ? w_addr_win : r_base;

    // ------------------------------------------------------------ stage 1
    // Holds the position flags while the VRAM performs its read.
    logic             r1_hact;
    logic             r1_vact;
    logic             r1_de;
    logic             r1_in_win;
    logic             r1_origin;
    logic [SEL_W-1:0] r1_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_hact   <= 1'b0;
            r1_vact   <= 1'b0;
            r1_de     <= 1'b0;
            r1_in_win <= 1'b0;
            r1_origin <= 1'b0;
            r1_sel    <= '0;
        end else begin
            r1_hact   <= w_hact;
            r1_vact   <= w_vact;
            r1_de     <= w_de;
            r1_in_win <= w_in_win;
            r1_origin <= w_origin;
            r1_sel    <= w_sel;
        end
    end

    // ------------------------------------------------------------ stage 2
    logic [BPP-1:0] w_pix;
    logic           r_hsync;
    logic           r_vsync;
    logic           r_de;
    logic [BPP-1:0] r_pixel;
    logic           r_frame_start;

    // Pixels are packed LSB-first within the word.
    assign w_pix = BPP'(bus.data_vram >> (32'(r1_sel) * 32'(BPP)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync       <= ~C_HS_ON;
            r_vsync       <= ~C_VS_ON;
            r_de          <= 1'b0;
            r_pixel       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= r1_hact ? C_HS_ON : ~C_HS_ON;
            r_vsync       <= r1_vact ? C_VS_ON : ~C_VS_ON;
            r_de          <= r1_de;
            r_pixel       <= r1_in_win ? w_pix : '0;
            r_frame_start <= r1_origin;
        end
    end

    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.de          = r_de;
    assign bus.pixel       = r_pixel;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scanout
// Description : Self-checking bench. Three scanout instances share one clock,
//               reset and a reduced 80x30 timing set (64x24 visible):
//                 A : BPP=1 SCALE=1 window (16,4) 32x8  -> WPL=2, PPW=16
//                 B : BPP=1 SCALE=2 window (0,0) 64x24  -> WPL=2, PPW=16
//                 C : BPP=2 SCALE=1 window (16,4) 32x8, hsync active-high
//                                                       -> WPL=4, PPW=8
//               Each instance reads its own synchronous-read VRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

    localparam int H_TOT = 80;
    localparam int V_TOT = 30;

    logic        clk;
    logic        rst;
    logic [12:0] base;
    int          checks;
    int          failures;
    int          m_h;
    int          m_v;

    logic [15:0] mem_a [0:8191];
    logic [15:0] mem_b [0:8191];
    logic [15:0] mem_c [0:8191];

    vga_scanout_if #(.ADDR_W(13), .DATA_W(16), .BPP(1)) bus_a ();
    vga_scanout_if #(.ADDR_W(13), .DATA_W(16), .BPP(1)) bus_b ();
    vga_scanout_if #(.ADDR_W(13), .DATA_W(16), .BPP(2)) bus_c ();

    vga_scanout #(
        .H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_DISPLAY(24), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(2),
        .HSYNC_POL(0), .VSYNC_POL(0),
        .WIN_X(16), .WIN_Y(4), .WIN_W(32), .WIN_H(8),
        .BPP(1), .SCALE(1), .DATA_W(16), .ADDR_W(13)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    vga_scanout #(
        .H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_DISPLAY(24), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(2),
        .HSYNC_POL(0), .VSYNC_POL(0),
        .WIN_X(0), .WIN_Y(0), .WIN_W(64), .WIN_H(24),
        .BPP(1), .SCALE(2), .DATA_W(16), .ADDR_W(13)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    vga_scanout #(
        .H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_DISPLAY(24), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(2),
        .HSYNC_POL(1), .VSYNC_POL(0),
        .WIN_X(16), .WIN_Y(4), .WIN_W(32), .WIN_H(8),
        .BPP(2), .SCALE(1), .DATA_W(16), .ADDR_W(13)
    ) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    assign bus_a.base_addr = base;
    assign bus_b.base_addr = base;
    assign bus_c.base_addr = base;

    // Synchronous-read VRAM models: data follows the address by one clock
    always @(posedge clk) begin
        bus_a.data_vram <= mem_a[bus_a.address_vram];
        bus_b.data_vram <= mem_b[bus_b.address_vram];
        bus_c.data_vram <= mem_c[bus_c.address_vram];
    end

    // Reference raster position of the counters during the current cycle
    always @(posedge clk) begin
        if (rst) begin
            m_h <= 0;
            m_v <= 0;
        end else if (m_h == H_TOT - 1) begin
            m_h <= 0;
            m_v <= (m_v == V_TOT - 1) ? 0 : m_v + 1;
        end else begin
            m_h <= m_h + 1;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until the counters sit at (th,tv); bounded by one frame plus margin
    task automatic goto(input int th, input int tv);
        int n;
        n = 0;
        while (!(m_h == th && m_v == tv) && n < 2600) begin
            step(1);
            n++;
        end
        checks++;
        if (!(m_h == th && m_v == tv)) begin
            failures++;
            $display("FAIL goto_timeout got=(%0d,%0d) required=(%0d,%0d)", m_h, m_v, th, tv);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        base = 13'd37;
        step(3);
        checks++; if (bus_a.address_vram !== 13'd37) begin failures++; $display("FAIL rst_addr_a got=%0d required=37", bus_a.address_vram); end
        checks++; if (bus_b.address_vram !== 13'd37) begin failures++; $display("FAIL rst_addr_b got=%0d required=37", bus_b.address_vram); end
        checks++; if (bus_a.hsync !== 1'b1 || bus_a.vsync !== 1'b1) begin failures++; $display("FAIL rst_sync_a got=%b%b required=11", bus_a.hsync, bus_a.vsync); end
        checks++; if (bus_c.hsync !== 1'b0) begin failures++; $display("FAIL rst_hsync_c got=%b required=0", bus_c.hsync); end
        checks++; if (bus_a.de !== 1'b0 || bus_a.frame_start !== 1'b0 || bus_a.pixel !== 1'b0) begin failures++; $display("FAIL rst_idle_a got de=%b fs=%b px=%b required=000", bus_a.de, bus_a.frame_start, bus_a.pixel); end
        base = 13'd0;
        step(1);
        rst = 1'b0;
        step(1);
        checks++; if (bus_a.frame_start !== 1'b0 || bus_a.de !== 1'b0) begin failures++; $display("FAIL rel_plus1 got fs=%b de=%b required=00", bus_a.frame_start, bus_a.de); end
        step(1);
        checks++; if (bus_a.frame_start !== 1'b1 || bus_a.de !== 1'b1) begin failures++; $display("FAIL rel_plus2 got fs=%b de=%b required=11", bus_a.frame_start, bus_a.de); end
        checks++; if (bus_a.hsync !== 1'b1) begin failures++; $display("FAIL rel_hsync got=%b required=1", bus_a.hsync); end
    endtask

    task automatic test_sync_edges();
        goto(67, 5); step(2);
        checks++; if (bus_a.hsync !== 1'b1) begin failures++; $display("FAIL hsync_h67 got=%b required=1", bus_a.hsync); end
        step(1);
        checks++; if (bus_a.hsync !== 1'b0) begin failures++; $display("FAIL hsync_h68 got=%b required=0", bus_a.hsync); end
        checks++; if (bus_c.hsync !== 1'b1) begin failures++; $display("FAIL hsync_pol_c got=%b required=1", bus_c.hsync); end
        checks++; if (bus_a.de !== 1'b0) begin failures++; $display("FAIL de_h68 got=%b required=0", bus_a.de); end
        goto(75, 5); step(2);
        checks++; if (bus_a.hsync !== 1'b0) begin failures++; $display("FAIL hsync_h75 got=%b required=0", bus_a.hsync); end
        step(1);
        checks++; if (bus_a.hsync !== 1'b1) begin failures++; $display("FAIL hsync_h76 got=%b required=1", bus_a.hsync); end
        goto(79, 25); step(2);
        checks++; if (bus_a.vsync !== 1'b1) begin failures++; $display("FAIL vsync_v25 got=%b required=1", bus_a.vsync); end
        step(1);
        checks++; if (bus_a.vsync !== 1'b0) begin failures++; $display("FAIL vsync_v26 got=%b required=0", bus_a.vsync); end
    endtask

    task automatic test_frame_counts();
        int hl, vl, de_n, fs_n, n;
        hl = 0; vl = 0; de_n = 0; fs_n = 0;
        for (int i = 0; i < H_TOT * V_TOT; i++) begin
            step(1);
            if (bus_a.hsync === 1'b0) hl++;
            if (bus_a.vsync === 1'b0) vl++;
            if (bus_a.de === 1'b1) de_n++;
            if (bus_a.frame_start === 1'b1) fs_n++;
        end
        checks++; if (hl != 240) begin failures++; $display("FAIL hsync_low_per_frame got=%0d required=240", hl); end
        checks++; if (vl != 160) begin failures++; $display("FAIL vsync_low_per_frame got=%0d required=160", vl); end
        checks++; if (de_n != 1536) begin failures++; $display("FAIL de_per_frame got=%0d required=1536", de_n); end
        checks++; if (fs_n != 1) begin failures++; $display("FAIL fs_per_frame got=%0d required=1", fs_n); end
        n = 0;
        while (bus_a.frame_start !== 1'b1 && n < 2500) begin step(1); n++; end
        step(1);
        n = 1;
        while (bus_a.frame_start !== 1'b1 && n < 2500) begin step(1); n++; end
        checks++; if (n != 2400) begin failures++; $display("FAIL frame_period got=%0d required=2400", n); end
    endtask

    task automatic test_addresses();
        int tac [6][4] = '{'{16, 4, 0, 0}, '{24, 4, 0, 1}, '{32, 4, 1, 2},
                           '{48, 4, 0, 0}, '{16, 5, 2, 4}, '{47, 11, 15, 31}};
        int tb_ [5][3] = '{'{31, 0, 0}, '{32, 0, 1}, '{0, 1, 0}, '{0, 2, 2}, '{63, 23, 23}};
        for (int i = 0; i < 6; i++) begin
            goto(tac[i][0], tac[i][1]);
            checks++; if (bus_a.address_vram !== 13'(tac[i][2])) begin failures++; $display("FAIL addr_a(%0d,%0d) got=%0d required=%0d", tac[i][0], tac[i][1], bus_a.address_vram, tac[i][2]); end
            checks++; if (bus_c.address_vram !== 13'(tac[i][3])) begin failures++; $display("FAIL addr_c(%0d,%0d) got=%0d required=%0d", tac[i][0], tac[i][1], bus_c.address_vram, tac[i][3]); end
        end
        for (int i = 0; i < 5; i++) begin
            goto(tb_[i][0], tb_[i][1]);
            checks++; if (bus_b.address_vram !== 13'(tb_[i][2])) begin failures++; $display("FAIL addr_b(%0d,%0d) got=%0d required=%0d", tb_[i][0], tb_[i][1], bus_b.address_vram, tb_[i][2]); end
        end
    endtask

    task automatic test_pixels();
        logic [1:0] exp_c [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        logic       exp_a [3] = '{1'b0, 1'b1, 1'b0};
        logic       exp_b [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        goto(15, 4); step(2);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                checks++; if (bus_a.pixel !== exp_a[i]) begin failures++; $display("FAIL pix_a_h%0d got=%0d required=%0d", 15 + i, bus_a.pixel, exp_a[i]); end
            end
            checks++; if (bus_c.pixel !== exp_c[i]) begin failures++; $display("FAIL pix_c_h%0d got=%0d required=%0d", 15 + i, bus_c.pixel, exp_c[i]); end
            step(1);
        end
        checks++; if (bus_c.pixel !== 2'd0) begin failures++; $display("FAIL pix_c_h20 got=%0d required=0", bus_c.pixel); end
        goto(0, 0); step(2);
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus_b.pixel !== exp_b[i]) begin failures++; $display("FAIL pix_b_h%0d got=%0d required=%0d", i, bus_b.pixel, exp_b[i]); end
            step(1);
        end
    endtask

    task automatic test_double_buffer();
        goto(16, 5);
        base = 13'd4096;
        goto(16, 6);
        checks++; if (bus_a.address_vram !== 13'd4) begin failures++; $display("FAIL db_hold_a got=%0d required=4", bus_a.address_vram); end
        checks++; if (bus_c.address_vram !== 13'd8) begin failures++; $display("FAIL db_hold_c got=%0d required=8", bus_c.address_vram); end
        goto(16, 4);
        checks++; if (bus_a.address_vram !== 13'd4096) begin failures++; $display("FAIL db_new_a got=%0d required=4096", bus_a.address_vram); end
        checks++; if (bus_c.address_vram !== 13'd4096) begin failures++; $display("FAIL db_new_c got=%0d required=4096", bus_c.address_vram); end
        goto(48, 5);
        checks++; if (bus_a.address_vram !== 13'd4096) begin failures++; $display("FAIL db_outside_a got=%0d required=4096", bus_a.address_vram); end
        base = 13'd8190;
        goto(47, 11);
        checks++; if (bus_a.address_vram !== 13'd4111) begin failures++; $display("FAIL db_hold2_a got=%0d required=4111", bus_a.address_vram); end
        goto(0, 0);
        goto(47, 11);
        checks++; if (bus_a.address_vram !== 13'd13) begin failures++; $display("FAIL addr_wrap_a got=%0d required=13", bus_a.address_vram); end
        checks++; if (bus_c.address_vram !== 13'd29) begin failures++; $display("FAIL addr_wrap_c got=%0d required=29", bus_c.address_vram); end
        base = 13'd0;
    endtask

    task automatic test_mid_reset();
        goto(0, 0);
        goto(30, 10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++; if (m_h != 0 || bus_a.address_vram !== 13'd0 || bus_b.address_vram !== 13'd0) begin failures++; $display("FAIL mrst_addr got a=%0d b=%0d required=0", bus_a.address_vram, bus_b.address_vram); end
        checks++; if (bus_a.hsync !== 1'b1 || bus_a.vsync !== 1'b1 || bus_a.de !== 1'b0) begin failures++; $display("FAIL mrst_idle got hs=%b vs=%b de=%b required=110", bus_a.hsync, bus_a.vsync, bus_a.de); end
        checks++; if (bus_a.pixel !== 1'b0 || bus_a.frame_start !== 1'b0) begin failures++; $display("FAIL mrst_pix got px=%b fs=%b required=00", bus_a.pixel, bus_a.frame_start); end
        step(1);
        checks++; if (bus_a.de !== 1'b0 || bus_a.frame_start !== 1'b0 || bus_a.hsync !== 1'b1) begin failures++; $display("FAIL mrst_plus1 got de=%b fs=%b hs=%b required=001", bus_a.de, bus_a.frame_start, bus_a.hsync); end
        step(1);
        checks++; if (bus_a.frame_start !== 1'b1 || bus_a.de !== 1'b1) begin failures++; $display("FAIL mrst_plus2 got fs=%b de=%b required=11", bus_a.frame_start, bus_a.de); end
        step(1);
        checks++; if (bus_a.frame_start !== 1'b0) begin failures++; $display("FAIL mrst_pulse_width got fs=%b required=0", bus_a.frame_start); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        base     = 13'd0;
        for (int i = 0; i < 8192; i++) begin
            mem_a[i] = 16'h0000;
            mem_b[i] = 16'h0000;
            mem_c[i] = 16'h0000;
        end
        mem_a[0] = 16'h0001;
        mem_b[0] = 16'h0003;
        mem_c[0] = 16'h00E4;

        test_reset();
        test_sync_edges();
        test_frame_counts();
        test_addresses();
        test_pixels();
        test_double_buffer();
        test_mid_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
